ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline register and EX operand front-end for the pipelined CPU. Captures decoded operands and control from the ID stage. Resolves EX/MEM and MEM/WB forwarding and the ALUSrc immediate select, then presents final `data1`/`data2`/`ALUCtrl` to the ALU and the control bits to the EX/MEM stage. Also detects load-use hazards and inserts the required bubble itself.

## Interface
- `DATA_W`, default 32: datapath width.
- `RA_W`, default 5: register address width.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset; synchronous, active-high.
- `stall_i` in 1: memory/cache stall; hold all state.
- `flush_i` in 1: branch flush; capture a bubble.
- `RS1data_i`, `RS2data_i`, `imm_i` in `DATA_W`: ID operands and sign-extended immediate.
- `RS1addr_i`, `RS2addr_i`, `RDaddr_i` in `RA_W`: ID register addresses.
- `ALUCtrl_i` in 3: ALU op (`AND`=000, `XOR`=001, `SLL`=010, `ADD`=011, `SUB`=100, `MUL`=101, `NoOp`=110, `SRAI`=111).
- `ALUSrc_i`, `RegWrite_i`, `MemtoReg_i`, `MemRead_i`, `MemWrite_i` in 1: ID control.
- `EXMEM_RegWrite_i` in 1, `EXMEM_RDaddr_i` in `RA_W`, `EXMEM_data_i` in `DATA_W`: EX/MEM forwarding source.
- `MEMWB_RegWrite_i` in 1, `MEMWB_RDaddr_i` in `RA_W`, `MEMWB_data_i` in `DATA_W`: MEM/WB forwarding source.
- `data1_o`, `data2_o` out `DATA_W`: ALU operands.
- `ALUCtrl_o` out 3: to ALU.
- `MemWdata_o` out `DATA_W`: forwarded rs2 value, used as the store data.
- `RDaddr_o` out `RA_W`, plus `RegWrite_o`, `MemtoReg_o`, `MemRead_o`, `MemWrite_o` out 1: to EX/MEM.
- `valid_o` out 1: the EX slot holds a real instruction.
- `load_use_o` out 1: combinational; PC and IF/ID must hold this cycle.

## Operation
- Registered state: all `*_i` ID fields plus a valid bit.
- A bubble sets `ALUCtrl`=`NoOp`, all control bits to 0, valid=0, and `RDaddr`=0. Data fields are don't-care but are cleared to 0.
- Per-edge priority:
  1. `rst_i`: capture a bubble.
  2. `stall_i`: hold everything. A `flush_i` or load-use in the same cycle is ignored; the requester must keep its request asserted.
  3. `flush_i`: capture a bubble.
  4. `load_use_o`: capture a bubble.
  5. Otherwise: capture the ID fields with valid=1.
- `load_use_o` = registered `MemRead` & valid & (`RDaddr`≠0) & (`RDaddr`==`RS1addr_i` | `RDaddr`==`RS2addr_i`).
  - It is 0 while `flush_i` is high.
  - It compares against the ID register addresses regardless of whether the ID instruction actually reads rs2. This conservative stall is accepted.
- Forwarding for operand A, using registered `RS1addr`:
  - EX/MEM hit (`EXMEM_RegWrite_i` & `EXMEM_RDaddr_i`≠0 & match): use `EXMEM_data_i`.
  - Else MEM/WB hit (same conditions): use `MEMWB_data_i`.
  - Else: use registered `RS1data`.
  - EX/MEM wins when both hit.
- Operand B: the same rule on `RS2addr` gives `fwdB`.
- Address 0 never forwards, so x0 reads its registered value.
- `data1_o` = `fwdA`.
- `data2_o` = `ALUSrc` ? registered `imm` : `fwdB`.
- `MemWdata_o` = `fwdB` always.
- Outputs are combinational from the registers and forwarding inputs. There is no arithmetic in this block, and all widths pass through unchanged.

## Timing
- Latency: ID fields presented at edge N appear on the outputs after edge N; the ALU consumes them in cycle N+1.
- Forwarding paths are combinational within the EX cycle; there is no extra register.
- After reset: `valid_o`=0, `ALUCtrl_o`=110, `RDaddr_o`=0, all control outputs 0, `data1_o`/`data2_o`/`MemWdata_o`=0 (provided the forwarding inputs are not hitting), `load_use_o`=0.
- A load-use hazard costs exactly one bubble. On the next edge the load has moved to EX/MEM, `load_use_o` drops, and the dependent instruction is captured. MEM/WB forwarding then supplies the loaded data one cycle later.
- Under a multi-cycle stall, the outputs stay constant in their registered part. Forwarded values may change if the EX/MEM or MEM/WB inputs change; the MEM stage holds them stable during a stall.
- Reset asserted mid-stall wins on the same edge.

## Test plan
- Reset: assert `rst_i` for 2 cycles with garbage on the inputs → `valid_o`=0, `ALUCtrl_o`=110, `RegWrite_o`=0, `load_use_o`=0.
- Forward priority:
  - Stimulus: capture `ADD` with rs1=5 (`RS1data`=1), rs2=6 (`RS2data`=2). Drive EX/MEM rd=5 data=0x10 and MEM/WB rd=5 data=0x20, both with RegWrite=1.
  - Required: `data1_o`=0x10, `data2_o`=2.
  - Then drop EX/MEM RegWrite → `data1_o`=0x20.
  - Then set EX/MEM rd=0 with RegWrite=1 → no EX/MEM forward.
- ALUSrc:
  - Stimulus: `ALUSrc`=1, `imm`=0xFFFFFFFC, rs2=7 forwarded from MEM/WB with 0xAB.
  - Required: `data2_o`=0xFFFFFFFC, `MemWdata_o`=0xAB.
- Load-use:
  - Stimulus: capture lw rd=3. The next ID instruction has rs1=3.
  - Required: `load_use_o`=1 for one cycle, the next edge captures a bubble (`valid_o`=0), and the following edge captures the dependent instruction.
- Stall vs flush:
  - Stimulus: capture `SUB` rd=4, then hold `stall_i`=1 for 3 cycles while pulsing `flush_i`.
  - Required: outputs unchanged (`ALUCtrl_o`=100, `RDaddr_o`=4).
  - Then `flush_i` with no stall → the next edge gives a bubble.
- Load-use during flush: lw rd=3 in EX, ID rs2=3, `flush_i`=1 → `load_use_o`=0 and a bubble is captured.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX operand forwarding, ALUSrc select and
// self-inserted load-use bubble.
module ex_operand_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] RS1data_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [RA_W-1:0]   RS1addr_i,
  input  logic [RA_W-1:0]   RS2addr_i,
  input  logic [RA_W-1:0]   RDaddr_i,
  input  logic [2:0]        ALUCtrl_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              EXMEM_RegWrite_i,
  input  logic [RA_W-1:0]   EXMEM_RDaddr_i,
  input  logic [DATA_W-1:0] EXMEM_data_i,
  input  logic              MEMWB_RegWrite_i,
  input  logic [RA_W-1:0]   MEMWB_RDaddr_i,
  input  logic [DATA_W-1:0] MEMWB_data_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [2:0]        ALUCtrl_o,
  output logic [DATA_W-1:0] MemWdata_o,
  output logic [RA_W-1:0]   RDaddr_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              valid_o,
  output logic              load_use_o
);

  localparam logic [2:0] ALU_NOOP = 3'b110;

  logic              valid_q,     valid_d;
  logic [2:0]        alu_ctrl_q,  alu_ctrl_d;
  logic [DATA_W-1:0] rs1_data_q,  rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q,  rs2_data_d;
  logic [DATA_W-1:0] imm_q,       imm_d;
  logic [RA_W-1:0]   rs1_addr_q,  rs1_addr_d;
  logic [RA_W-1:0]   rs2_addr_q,  rs2_addr_d;
  logic [RA_W-1:0]   rd_addr_q,   rd_addr_d;
  logic              alu_src_q,   alu_src_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic              rd_nonzero;
  logic              rd_matches_id;

  // Load in EX whose destination feeds the instruction sitting in ID.
  assign rd_nonzero    = (rd_addr_q != '0);
  assign rd_matches_id = (rd_addr_q == RS1addr_i) || (rd_addr_q == RS2addr_i);
  assign load_use_o    = mem_read_q && valid_q && rd_nonzero && rd_matches_id && !flush_i;

  // Next-state: hold on stall, bubble on flush/load-use, else capture ID.
  always_comb begin
    valid_d      = valid_q;
    alu_ctrl_d   = alu_ctrl_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_addr_d   = rs1_addr_q;
    rs2_addr_d   = rs2_addr_q;
    rd_addr_d    = rd_addr_q;
    alu_src_d    = alu_src_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    if (!stall_i) begin
      if (flush_i || load_use_o) begin
        valid_d      = 1'b0;
        alu_ctrl_d   = ALU_NOOP;
        rs1_data_d   = '0;
        rs2_data_d   = '0;
        imm_d        = '0;
        rs1_addr_d   = '0;
        rs2_addr_d   = '0;
        rd_addr_d    = '0;
        alu_src_d    = 1'b0;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
      end else begin
        valid_d      = 1'b1;
        alu_ctrl_d   = ALUCtrl_i;
        rs1_data_d   = RS1data_i;
        rs2_data_d   = RS2data_i;
        imm_d        = imm_i;
        rs1_addr_d   = RS1addr_i;
        rs2_addr_d   = RS2addr_i;
        rd_addr_d    = RDaddr_i;
        alu_src_d    = ALUSrc_i;
        reg_write_d  = RegWrite_i;
        mem_to_reg_d = MemtoReg_i;
        mem_read_d   = MemRead_i;
        mem_write_d  = MemWrite_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      alu_ctrl_q   <= ALU_NOOP;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_addr_q   <= rs1_addr_d;
      rs2_addr_q   <= rs2_addr_d;
      rd_addr_q    <= rd_addr_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
    end
  end

  // Forwarding: EX/MEM is the younger producer and wins; x0 never forwards.
  always_comb begin
    fwd_a = rs1_data_q;
    if (EXMEM_RegWrite_i && (EXMEM_RDaddr_i != '0) && (EXMEM_RDaddr_i == rs1_addr_q)) begin
      fwd_a = EXMEM_data_i;
    end else if (MEMWB_RegWrite_i && (MEMWB_RDaddr_i != '0) && (MEMWB_RDaddr_i == rs1_addr_q)) begin
      fwd_a = MEMWB_data_i;
    end
  end

  always_comb begin
    fwd_b = rs2_data_q;
    if (EXMEM_RegWrite_i && (EXMEM_RDaddr_i != '0) && (EXMEM_RDaddr_i == rs2_addr_q)) begin
      fwd_b = EXMEM_data_i;
    end else if (MEMWB_RegWrite_i && (MEMWB_RDaddr_i != '0) && (MEMWB_RDaddr_i == rs2_addr_q)) begin
      fwd_b = MEMWB_data_i;
    end
  end

  assign data1_o    = fwd_a;
  assign data2_o    = alu_src_q ? imm_q : fwd_b;
  assign MemWdata_o = fwd_b;
  assign ALUCtrl_o  = alu_ctrl_q;
  assign RDaddr_o   = rd_addr_q;
  assign RegWrite_o = reg_write_q;
  assign MemtoReg_o = mem_to_reg_q;
  assign MemRead_o  = mem_read_q;
  assign MemWrite_o = mem_write_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed scenarios then random traffic
// checked against an instruction-slot reference model.
module tb_ex_operand_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, stall_i, flush_i;
  logic [31:0] RS1data_i, RS2data_i, imm_i;
  logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;
  logic [2:0]  ALUCtrl_i;
  logic        ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic        EXMEM_RegWrite_i, MEMWB_RegWrite_i;
  logic [4:0]  EXMEM_RDaddr_i, MEMWB_RDaddr_i;
  logic [31:0] EXMEM_data_i, MEMWB_data_i;
  logic [31:0] data1_o, data2_o, MemWdata_o;
  logic [2:0]  ALUCtrl_o;
  logic [4:0]  RDaddr_o;
  logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, valid_o, load_use_o;

  ex_operand_stage #(.DATA_W(32), .RA_W(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .imm_i(imm_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .ALUCtrl_i(ALUCtrl_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i),
    .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .EXMEM_RegWrite_i(EXMEM_RegWrite_i), .EXMEM_RDaddr_i(EXMEM_RDaddr_i),
    .EXMEM_data_i(EXMEM_data_i), .MEMWB_RegWrite_i(MEMWB_RegWrite_i),
    .MEMWB_RDaddr_i(MEMWB_RDaddr_i), .MEMWB_data_i(MEMWB_data_i),
    .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(ALUCtrl_o),
    .MemWdata_o(MemWdata_o), .RDaddr_o(RDaddr_o), .RegWrite_o(RegWrite_o),
    .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .valid_o(valid_o), .load_use_o(load_use_o)
  );

  typedef struct {
    logic rst, stall, flush;
    logic [31:0] rs1d, rs2d, imm;
    logic [4:0] rs1a, rs2a, rda;
    logic [2:0] alu;
    logic alusrc, rw, m2r, mr, mw;
    logic exw; logic [4:0] exrd; logic [31:0] exd;
    logic wbw; logic [4:0] wbrd; logic [31:0] wbd;
  } stim_t;

  // One instruction occupying the EX slot.
  typedef struct {
    logic valid; logic [2:0] alu; logic [4:0] rd, rs1, rs2;
    logic [31:0] d1, d2, imm; logic alusrc, rw, m2r, mr, mw;
  } slot_t;

  typedef struct {
    logic valid; logic [2:0] alu; logic [4:0] rd; logic rw, m2r, mr, mw;
    logic [31:0] d1, d2, mwd; logic lu;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  mon_e;
  slot_t ex_slot, ex_next;
  bit    known, known_next;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic slot_t bubble();
    slot_t b;
    b = '{default: '0};
    b.alu = 3'b110;
    return b;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.alu = 3'b110;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst = ($urandom_range(0, 99) < 3);  s.stall = ($urandom_range(0, 99) < 15);
    s.flush = ($urandom_range(0, 99) < 10);
    s.rs1d = $urandom; s.rs2d = $urandom; s.imm = $urandom;
    s.rs1a = 5'($urandom_range(0, 7)); s.rs2a = 5'($urandom_range(0, 7));
    s.rda = 5'($urandom_range(0, 7)); s.alu = 3'($urandom_range(0, 7));
    s.alusrc = 1'($urandom); s.rw = 1'($urandom); s.m2r = 1'($urandom);
    s.mr = ($urandom_range(0, 99) < 35); s.mw = 1'($urandom);
    s.exw = 1'($urandom); s.exrd = 5'($urandom_range(0, 7)); s.exd = $urandom;
    s.wbw = 1'($urandom); s.wbrd = 5'($urandom_range(0, 7)); s.wbd = $urandom;
    return s;
  endfunction

  // Most recent value of a register as seen by EX: newest writer in flight, else captured.
  function automatic logic [31:0] newest(input logic [4:0] a, input logic [31:0] own, input stim_t s);
    if (a == 5'd0) return own;
    if (s.exw && s.exrd == a) return s.exd;
    if (s.wbw && s.wbrd == a) return s.wbd;
    return own;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    logic lu;
    rst_i = s.rst; stall_i = s.stall; flush_i = s.flush;
    RS1data_i = s.rs1d; RS2data_i = s.rs2d; imm_i = s.imm;
    RS1addr_i = s.rs1a; RS2addr_i = s.rs2a; RDaddr_i = s.rda;
    ALUCtrl_i = s.alu; ALUSrc_i = s.alusrc; RegWrite_i = s.rw;
    MemtoReg_i = s.m2r; MemRead_i = s.mr; MemWrite_i = s.mw;
    EXMEM_RegWrite_i = s.exw; EXMEM_RDaddr_i = s.exrd; EXMEM_data_i = s.exd;
    MEMWB_RegWrite_i = s.wbw; MEMWB_RDaddr_i = s.wbrd; MEMWB_data_i = s.wbd;
    lu = 1'b0;
    if (known) begin
      lu = ex_slot.valid && ex_slot.mr && ex_slot.rd != 5'd0 && !s.flush &&
           (ex_slot.rd == s.rs1a || ex_slot.rd == s.rs2a);
      e.valid = ex_slot.valid; e.alu = ex_slot.alu; e.rd = ex_slot.rd;
      e.rw = ex_slot.rw; e.m2r = ex_slot.m2r; e.mr = ex_slot.mr; e.mw = ex_slot.mw;
      e.d1  = newest(ex_slot.rs1, ex_slot.d1, s);
      e.mwd = newest(ex_slot.rs2, ex_slot.d2, s);
      e.d2  = ex_slot.alusrc ? ex_slot.imm : e.mwd;
      e.lu  = lu;
      sb_q.push_back(e);
    end
    known_next = known;
    ex_next    = ex_slot;
    if (s.rst) begin
      ex_next = bubble(); known_next = 1'b1;
    end else if (!s.stall) begin
      if (s.flush || lu) ex_next = bubble();
      else begin
        ex_next = '{valid: 1'b1, alu: s.alu, rd: s.rda, rs1: s.rs1a, rs2: s.rs2a,
                    d1: s.rs1d, d2: s.rs2d, imm: s.imm, alusrc: s.alusrc,
                    rw: s.rw, m2r: s.m2r, mr: s.mr, mw: s.mw};
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ex_slot = ex_next;
    known   = known_next;
  endtask

  task automatic cyc(input stim_t s);
    drive(s);
    tick();
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      chk("valid_o",    32'(valid_o),    32'(mon_e.valid));
      chk("ALUCtrl_o",  32'(ALUCtrl_o),  32'(mon_e.alu));
      chk("RDaddr_o",   32'(RDaddr_o),   32'(mon_e.rd));
      chk("RegWrite_o", 32'(RegWrite_o), 32'(mon_e.rw));
      chk("MemtoReg_o", 32'(MemtoReg_o), 32'(mon_e.m2r));
      chk("MemRead_o",  32'(MemRead_o),  32'(mon_e.mr));
      chk("MemWrite_o", 32'(MemWrite_o), 32'(mon_e.mw));
      chk("data1_o",    data1_o,         mon_e.d1);
      chk("data2_o",    data2_o,         mon_e.d2);
      chk("MemWdata_o", MemWdata_o,      mon_e.mwd);
      chk("load_use_o", 32'(load_use_o), 32'(mon_e.lu));
    end
  end

  initial begin
    stim_t s;
    known = 1'b0;
    ex_slot = bubble();

    // Reset with garbage inputs
    s = rand_stim(); s.rst = 1'b1; cyc(s);
    s = rand_stim(); s.rst = 1'b1; cyc(s);
    s = rand_stim(); s.rst = 1'b0; s.mr = 1'b0; drive(s); #1;
    chk("rst valid", 32'(valid_o), 32'd0);
    chk("rst alu", 32'(ALUCtrl_o), 32'd6);
    chk("rst regwrite", 32'(RegWrite_o), 32'd0);
    chk("rst load_use", 32'(load_use_o), 32'd0);
    chk("rst data1", data1_o, 32'd0);
    tick();

    // Forward priority
    s = idle(); s.alu = 3'b011; s.rs1a = 5'd5; s.rs1d = 32'd1; s.rs2a = 5'd6; s.rs2d = 32'd2;
    s.rda = 5'd8; s.rw = 1'b1; cyc(s);
    s = idle(); s.stall = 1'b1; s.exw = 1'b1; s.exrd = 5'd5; s.exd = 32'h10;
    s.wbw = 1'b1; s.wbrd = 5'd5; s.wbd = 32'h20; drive(s); #1;
    chk("fwd exmem wins", data1_o, 32'h10);
    chk("fwd rs2 none", data2_o, 32'd2);
    tick();
    s.exw = 1'b0; drive(s); #1;
    chk("fwd memwb", data1_o, 32'h20);
    tick();
    s.exw = 1'b1; s.exrd = 5'd0; drive(s); #1;
    chk("fwd exmem x0", data1_o, 32'h20);
    tick();
    s.wbw = 1'b0; drive(s); #1;
    chk("fwd none", data1_o, 32'd1);
    tick();

    // ALUSrc
    s = idle(); s.alu = 3'b011; s.alusrc = 1'b1; s.imm = 32'hFFFF_FFFC; s.rs2a = 5'd7;
    s.rs2d = 32'd5; cyc(s);
    s = idle(); s.stall = 1'b1; s.wbw = 1'b1; s.wbrd = 5'd7; s.wbd = 32'hAB; drive(s); #1;
    chk("alusrc data2", data2_o, 32'hFFFF_FFFC);
    chk("alusrc memwdata", MemWdata_o, 32'hAB);
    tick();

    // Load-use: one bubble then the dependent instruction
    s = idle(); s.alu = 3'b011; s.mr = 1'b1; s.rw = 1'b1; s.m2r = 1'b1; s.rda = 5'd3;
    s.alusrc = 1'b1; cyc(s);
    s = idle(); s.alu = 3'b011; s.rs1a = 5'd3; s.rda = 5'd9; s.rw = 1'b1; drive(s); #1;
    chk("lu asserted", 32'(load_use_o), 32'd1);
    tick();
    drive(s); #1;
    chk("lu dropped", 32'(load_use_o), 32'd0);
    chk("lu bubble valid", 32'(valid_o), 32'd0);
    tick();
    drive(idle()); #1;
    chk("lu dep valid", 32'(valid_o), 32'd1);
    chk("lu dep rd", 32'(RDaddr_o), 32'd9);
    tick();

    // Stall beats flush
    s = idle(); s.alu = 3'b100; s.rda = 5'd4; s.rw = 1'b1; cyc(s);
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.rst = 1'b0; s.stall = 1'b1; s.flush = (i != 1);
      drive(s); #1;
      chk("stall alu", 32'(ALUCtrl_o), 32'd4);
      chk("stall rd", 32'(RDaddr_o), 32'd4);
      tick();
    end
    s = idle(); s.flush = 1'b1; cyc(s);
    drive(idle()); #1;
    chk("flush valid", 32'(valid_o), 32'd0);
    chk("flush alu", 32'(ALUCtrl_o), 32'd6);
    chk("flush rd", 32'(RDaddr_o), 32'd0);
    tick();

    // Load-use suppressed by flush
    s = idle(); s.mr = 1'b1; s.rw = 1'b1; s.rda = 5'd3; cyc(s);
    s = idle(); s.rs2a = 5'd3; s.flush = 1'b1; drive(s); #1;
    chk("lu under flush", 32'(load_use_o), 32'd0);
    tick();
    drive(idle()); #1;
    chk("flush bubble", 32'(valid_o), 32'd0);
    tick();

    // Random traffic
    for (int n = 0; n < 600; n++) cyc(rand_stim());

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
